clk_en_sequencer: RTL and testbench
===================================

# clk_en_sequencer

Post-PLL clock supervisor and clock-enable generator for the DAC datapath. It synchronises the PLL `lock` output, waits for a hold-off period of continuous lock, and releases per-channel synchronous resets in a staggered order. Once a channel is out of reset it produces a fractional-rate clock-enable strobe from a phase accumulator. It runs on the PLL output clock and replaces ad-hoc lock gating and fixed divide counters downstream of the PLL.

## Interface
- `N_CH`, 2: number of output channels, 1..8.
- `ACC_W`, 32: phase accumulator width, 8..32.
- `SYNC_STAGES`, 2: lock synchroniser depth, at least 2.
- `HOLDOFF`, 1024: cycles of continuous synchronised lock required before release, at least 1.
- `GAP`, 16: cycles between successive channel reset releases, at least 1.
- `clk  in  1`  PLL output clock; only clock.
- `rst_n  in  1`  synchronous, active-low reset.
- `pll_lock_i  in  1`  raw PLL lock, asynchronous to `clk`.
- `ch_inc_i  in  N_CH*ACC_W`  per-channel phase increment; channel k is bits [k*ACC_W +: ACC_W].
- `ch_run_i  in  N_CH`  per-channel run enable.
- `ready_o  out  1`  high in RUN only.
- `ch_rst_n_o  out  N_CH`  per-channel synchronous active-low reset.
- `ch_ce_o  out  N_CH`  per-channel single-cycle clock-enable strobe.
- `lost_cnt_o  out  8`  saturating count of lock-loss events.

## Operation
- Reset (`rst_n`=0 at a clk edge): FSM goes to WAIT_LOCK; synchroniser, counters and accumulators are cleared; `ready_o`=0, `ch_rst_n_o`=0, `ch_ce_o`=0, `lost_cnt_o`=0.
- `lock_s` is `pll_lock_i` after `SYNC_STAGES` flops. It is the only lock signal the logic uses.
- FSM states are WAIT_LOCK, HOLDOFF, RELEASE and RUN.
  - WAIT_LOCK → HOLDOFF when `lock_s`=1. The hold-off counter is cleared on entry.
  - HOLDOFF: the counter increments every cycle. → RELEASE when the counter reaches `HOLDOFF`-1.
  - RELEASE: channel 0 is released on entry. Channel k is released k*`GAP` cycles after entry. → RUN on the cycle the last channel is released.
  - RUN: steady state.
- Lock loss: `lock_s`=0 in HOLDOFF, RELEASE or RUN causes the following.
  - The FSM goes to WAIT_LOCK.
  - All `ch_rst_n_o` go to 0, all accumulators clear, and `ready_o` goes to 0, all on the next edge.
  - `lost_cnt_o` increments and saturates at 255.
  - Lock loss takes priority over every other transition in the same cycle.
- A lock glitch shorter than one cycle may be missed. That is acceptable.
- Per-channel CE behaviour:
  - The accumulator is active when `ch_rst_n_o[k]`=1 and `ch_run_i[k]`=1.
  - When active, on each cycle: `{carry, acc} <= acc + inc` (ACC_W+1-bit add), and `ch_ce_o[k] <= carry`.
  - When inactive: `acc` is held at 0 and `ch_ce_o[k]` is 0.
  - Strobe rate is f_clk·inc/2^ACC_W. `inc`=0 gives no strobes. The increment is sampled every cycle, so changes apply immediately and the accumulated phase is kept.
  - Dropping `ch_run_i[k]` clears the accumulator. Re-asserting it restarts from phase 0.

## Timing
- `lock_s` rises `SYNC_STAGES` cycles after `pll_lock_i` rises.
- Release latency from the `lock_s` rise to `ch_rst_n_o[0]`=1 is `HOLDOFF`+1 cycles.
- `ch_rst_n_o[k]` rises k*`GAP` cycles after `ch_rst_n_o[0]`.
- `ready_o` rises in the same cycle as `ch_rst_n_o[N_CH-1]`.
- First strobe: with the accumulator active from cycle t and constant `inc`, the first `ch_ce_o` is at cycle t+ceil(2^ACC_W/inc). Steady-state spacing is within ±1 cycle of 2^ACC_W/inc.
- On lock loss, `ch_rst_n_o`, `ready_o` and `ch_ce_o` are all 0 one cycle after `lock_s` falls.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `clk_seq_pkg` holds:
  - the FSM state enum `seq_state_t`;
  - the `LOST_W`=8 constant;
  - a `clog2`-based width helper for the hold-off and gap counters.
- Sub-module `phase_acc_ce` (parameter `ACC_W`; ports `clk`, `rst_n`, `en`, `inc`, `ce`) is instantiated `N_CH` times by a generate loop.
- The synchroniser, FSM, counters and `lost_cnt` live in the top level.

## Test plan
Bench parameters: `N_CH`=2, `ACC_W`=8, `SYNC_STAGES`=2, `HOLDOFF`=8, `GAP`=4.
1. `pll_lock_i` held at 1 from reset release → `ch_rst_n_o[0]` rises 11 cycles later (2 sync + 8 hold-off + 1), `ch_rst_n_o[1]` and `ready_o` rise 4 cycles after that; `lost_cnt_o`=0.
2. `ch_run_i`=2'b11, `inc0`=64, `inc1`=128 → ch0 strobes every 4 cycles and ch1 every 2 cycles. With `inc0`=255, ch0 gives 255 strobes in 256 cycles. With `inc0`=0, ch0 gives no strobes.
3. Lock drop for 3 cycles in RUN → one cycle after `lock_s` falls, `ch_rst_n_o`=0, `ready_o`=0 and `ch_ce_o`=0; `lost_cnt_o`=1; the full release sequence repeats after lock returns.
4. Lock drop at hold-off count 5 → return to WAIT_LOCK; the hold-off restarts from 0; `lost_cnt_o` increments.
5. 300 lock-loss events → `lost_cnt_o` saturates at 255.
6. `rst_n` asserted mid-RELEASE (ch0 released, ch1 not) → next edge shows all outputs at their reset values and the FSM in WAIT_LOCK.

Source files
------------

// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the post-PLL clock-enable sequencer.
package clk_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_HOLDOFF,
        ST_RELEASE,
        ST_RUN
    } seq_state_t;

    localparam int LOST_W = 8;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_acc_ce.sv
// Per-channel phase accumulator; the carry out of each add becomes a one-cycle CE strobe.
module phase_acc_ce #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q;
    logic             ce_q;
    logic [ACC_W:0]   acc_d;

    assign acc_d = {1'b0, acc_q} + {1'b0, inc};

    // Disabled channels sit at phase 0 so a restart always begins from a known phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else if (en) begin
            acc_q <= acc_d[ACC_W-1:0];
            ce_q  <= acc_d[ACC_W];
        end else begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/clk_en_sequencer.sv
// Lock supervisor: synchronises PLL lock, waits a hold-off, releases channel resets
// in a staggered order, and drives per-channel fractional CE strobes.
module clk_en_sequencer
    import clk_seq_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int ACC_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1024,
    parameter int GAP         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock_i,
    input  logic [N_CH*ACC_W-1:0]   ch_inc_i,
    input  logic [N_CH-1:0]         ch_run_i,
    output logic                    ready_o,
    output logic [N_CH-1:0]         ch_rst_n_o,
    output logic [N_CH-1:0]         ch_ce_o,
    output logic [LOST_W-1:0]       lost_cnt_o
);

    localparam int HOLD_W = cnt_w(HOLDOFF);
    localparam int GAP_W  = cnt_w(GAP);
    localparam int IDX_W  = cnt_w(N_CH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    seq_state_t             state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_CH-1:0]        ch_rst_n_q, ch_rst_n_d;
    logic [LOST_W-1:0]      lost_q, lost_d;
    logic                   lose;
    logic [N_CH-1:0]        ch_en;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign lose   = (state_q != ST_WAIT_LOCK) && !lock_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= ST_WAIT_LOCK;
            hold_q     <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            ch_rst_n_q <= '0;
            lost_q     <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            ch_rst_n_q <= ch_rst_n_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        ch_rst_n_d = ch_rst_n_q;
        lost_d     = lost_q;
        if (lose) begin
            state_d    = ST_WAIT_LOCK;
            hold_d     = '0;
            gap_d      = '0;
            idx_d      = '0;
            ch_rst_n_d = '0;
            if (lost_q != '1) lost_d = lost_q + 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_HOLDOFF;
                        hold_d  = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q == HOLD_W'(HOLDOFF - 1)) begin
                        ch_rst_n_d[0] = 1'b1;
                        gap_d         = '0;
                        idx_d         = IDX_W'(1);
                        // A single channel is fully released on entry, so skip straight to RUN.
                        state_d       = (N_CH == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        gap_d             = '0;
                        ch_rst_n_d[idx_q] = 1'b1;
                        idx_d             = idx_q + 1'b1;
                        if (idx_q == IDX_W'(N_CH - 1)) state_d = ST_RUN;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with the loss condition clears the strobes on the same edge as the resets.
    assign ch_en = ch_rst_n_q & ch_run_i & {N_CH{!lose}};

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        phase_acc_ce #(.ACC_W(ACC_W)) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ch_en[k]),
            .inc   (ch_inc_i[k*ACC_W +: ACC_W]),
            .ce    (ch_ce_o[k])
        );
    end

    assign ready_o    = (state_q == ST_RUN);
    assign ch_rst_n_o = ch_rst_n_q;
    assign lost_cnt_o = lost_q;

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Randomised bench for clk_en_sequencer checked every cycle against a lock-run-length model.
module tb_clk_en_sequencer;

    localparam int N_CH = 2, ACC_W = 8, SYNC = 2, HOLDOFF = 8, GAP = 4;

    logic                  clk = 1'b0;
    logic                  rst_n, pll;
    logic [N_CH*ACC_W-1:0] inc;
    logic [N_CH-1:0]       run;
    logic                  ready;
    logic [N_CH-1:0]       ch_rst_n, ch_ce;
    logic [7:0]            lost;

    always #5 clk = ~clk;

    clk_en_sequencer #(
        .N_CH(N_CH), .ACC_W(ACC_W), .SYNC_STAGES(SYNC), .HOLDOFF(HOLDOFF), .GAP(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock_i (pll),
        .ch_inc_i   (inc),
        .ch_run_i   (run),
        .ready_o    (ready),
        .ch_rst_n_o (ch_rst_n),
        .ch_ce_o    (ch_ce),
        .lost_cnt_o (lost)
    );

    int vectors = 0, miscompares = 0;

    // Model: lock history, length of the current unbroken run of synchronised lock
    // samples, and per-channel phase as a plain integer.
    bit          hist [SYNC];
    int          run_len;
    int          phase [N_CH];
    bit [N_CH-1:0] m_rst, m_ce;
    bit          m_ready;
    int          m_lost;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit s, ls;
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
            for (int k = 0; k < N_CH; k++) phase[k] = 0;
            run_len = 0; m_rst = '0; m_ce = '0; m_ready = 0; m_lost = 0;
            return;
        end
        s = hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pll;
        ls = !s && (run_len >= 1);
        for (int k = 0; k < N_CH; k++) begin
            if (m_rst[k] && run[k] && !ls) begin
                phase[k] += int'(inc[k*ACC_W +: ACC_W]);
                m_ce[k] = (phase[k] >= (1 << ACC_W));
                if (m_ce[k]) phase[k] -= (1 << ACC_W);
            end else begin
                phase[k] = 0;
                m_ce[k]  = 0;
            end
        end
        if (s) begin
            if (run_len < 1000000) run_len++;
        end else begin
            run_len = 0;
        end
        if (ls && m_lost < 255) m_lost++;
        for (int k = 0; k < N_CH; k++) m_rst[k] = (run_len >= HOLDOFF + 1 + k*GAP);
        m_ready = (run_len >= HOLDOFF + 1 + (N_CH-1)*GAP);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(m_ready));
        chk("ch_rst_n", 32'(ch_rst_n), 32'(m_rst));
        chk("ch_ce", 32'(ch_ce), 32'(m_ce));
        chk("lost_cnt", 32'(lost), 32'(m_lost));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ch(input int k, output int n);
        n = 0;
        while (!ch_rst_n[k] && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic count_ce(input int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c0 += int'(ch_ce[0]);
            c1 += int'(ch_ce[1]);
        end
    endtask

    initial begin
        int n, c0, c1;
        rst_n = 1'b0; pll = 1'b0; inc = '0; run = '0;
        steps(3);
        chk("rst_ch_rst_n", 32'(ch_rst_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);

        // Release sequence with lock held from reset release.
        rst_n = 1'b1; pll = 1'b1;
        wait_ch(0, n);
        chk("t1_ch0_latency", 32'(n), 32'd11);
        wait_ch(1, n);
        chk("t1_ch1_gap", 32'(n), 32'd4);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_lost", 32'(lost), 32'd0);

        // Strobe rates.
        inc = {8'd128, 8'd64}; run = 2'b11;
        count_ce(16, c0, c1);
        chk("t2_ch0_inc64", 32'(c0), 32'd4);
        chk("t2_ch1_inc128", 32'(c1), 32'd8);
        run[0] = 1'b0; step();
        inc[7:0] = 8'd255; run[0] = 1'b1;
        count_ce(256, c0, c1);
        chk("t2_ch0_inc255", 32'(c0), 32'd255);
        inc[7:0] = 8'd0;
        count_ce(64, c0, c1);
        chk("t2_ch0_inc0", 32'(c0), 32'd0);

        // Three-cycle lock drop in RUN.
        inc = {8'd128, 8'd64};
        pll = 1'b0; steps(3);
        chk("t3_ch_rst_n", 32'(ch_rst_n), 32'd0);
        chk("t3_ready", 32'(ready), 32'd0);
        chk("t3_ce", 32'(ch_ce), 32'd0);
        chk("t3_lost", 32'(lost), 32'd1);
        pll = 1'b1; steps(30);
        chk("t3_ready_again", 32'(ready), 32'd1);

        // Random increments, run enables and sparse lock glitches.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) inc = N_CH*ACC_W'($urandom);
            if ($urandom_range(0, 63) == 0) run = N_CH'($urandom);
            pll = ($urandom_range(0, 299) != 0);
            step();
        end

        // Lock drop at hold-off count 5.
        rst_n = 1'b0; step();
        rst_n = 1'b1; pll = 1'b1; steps(6);
        pll = 1'b0; steps(2);
        pll = 1'b1;
        wait_ch(0, n);
        chk("t4_restart_latency", 32'(n), 32'd11);
        chk("t4_lost", 32'(lost), 32'd1);

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            pll = 1'b1; steps(3);
            pll = 1'b0; steps(3);
        end
        chk("t5_lost_sat", 32'(lost), 32'd255);

        // Reset in the middle of the release sequence.
        rst_n = 1'b0; step();
        rst_n = 1'b1; pll = 1'b1;
        wait_ch(0, n);
        step();
        chk("t6_mid_release", 32'(ch_rst_n), 32'b01);
        rst_n = 1'b0; step();
        chk("t6_ch_rst_n", 32'(ch_rst_n), 32'd0);
        chk("t6_ready", 32'(ready), 32'd0);
        chk("t6_ce", 32'(ch_ce), 32'd0);
        chk("t6_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        wait_ch(0, n);
        chk("t6_rerelease_latency", 32'(n), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
